// File: rtl/midi_fpga_pkg.sv
// Shared MIDI controller definitions: MIDI-in FSM state encodings and the
// footswitch event record handed to the preset/MIDI-out logic.
package midi_fpga_pkg;

  localparam logic [1:0] MIDI_ST_IDLE  = 2'd0;
  localparam logic [1:0] MIDI_ST_LEARN = 2'd1;

  // Wide enough for channel+1 with up to 15 channels.
  localparam int EVT_IDX_W = 4;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] idx;
    logic                 save;
    logic                 long;
  } btn_event_t;

endpackage

// File: rtl/btn_debounce.sv
// One footswitch channel: 2-flop synchroniser, stability-counter debounce,
// and hold counter that flags a long press once per press.
module btn_debounce #(
  parameter int DEB_W  = 21,
  parameter int LONG_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic long_pulse
);

  logic              sync1_q, sync2_q;
  logic [1:0]        warm_q;
  logic              armed_q, armed_d;
  logic              level_q, level_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic              pressed_q, pressed_d;
  logic [LONG_W-1:0] hold_q, hold_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      warm_q    <= '0;
      armed_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_q     <= '0;
      pressed_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      sync1_q   <= ~btn_n;
      sync2_q   <= sync1_q;
      warm_q    <= {warm_q[0], 1'b1};
      armed_q   <= armed_d;
      level_q   <= level_d;
      deb_q     <= deb_d;
      pressed_q <= pressed_d;
      hold_q    <= hold_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    deb_d       = '0;
    level_d     = level_q;
    pressed_d   = pressed_q;
    hold_d      = hold_q;
    press_pulse = 1'b0;
    long_pulse  = 1'b0;

    if (sync2_q != level_q) begin
      if (&deb_q) level_d = sync2_q;
      else        deb_d   = deb_q + 1'b1;
    end

    // A switch held through reset must be seen released (once the
    // synchroniser holds real samples) before it can raise a press.
    armed_d     = armed_q | (warm_q[1] & ~sync2_q);
    press_pulse = level_d & ~level_q & armed_q;

    if (press_pulse) begin
      pressed_d = 1'b1;
      hold_d    = '0;
    end else if (!level_q) begin
      pressed_d = 1'b0;
      hold_d    = '0;
    end else if (pressed_q && !(&hold_q)) begin
      hold_d     = hold_q + 1'b1;
      long_pulse = &hold_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/footswitch_scanner.sv
// N-channel footswitch front end: per-channel debounce, pending press and
// long-press masks, and a fixed-priority arbiter producing one event per cycle.
module footswitch_scanner
  import midi_fpga_pkg::*;
#(
  parameter int NUM_BTN = 5,
  parameter int IDX_W   = 4,
  parameter int DEB_W   = 21,
  parameter int LONG_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic [1:0]         midi_in_state,
  output logic               btn_valid,
  output logic [IDX_W-1:0]   btn_index,
  output logic               save_mode,
  output logic               long_press,
  output logic [NUM_BTN-1:0] btn_held
);

  logic [NUM_BTN-1:0] press_w, long_w, grant;
  logic [NUM_BTN-1:0] short_pend_q, short_pend_d;
  logic [NUM_BTN-1:0] long_pend_q, long_pend_d;
  logic               valid_q, valid_d;
  btn_event_t         evt_q, evt_d;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_debounce #(
      .DEB_W (DEB_W),
      .LONG_W(LONG_W)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n[gi]),
      .level      (btn_held[gi]),
      .press_pulse(press_w[gi]),
      .long_pulse (long_w[gi])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      short_pend_q <= '0;
      long_pend_q  <= '0;
      valid_q      <= 1'b0;
      evt_q        <= '0;
    end else begin
      short_pend_q <= short_pend_d;
      long_pend_q  <= long_pend_d;
      valid_q      <= valid_d;
      evt_q        <= evt_d;
    end
  end

  // Long events outrank short ones; x & -x isolates the lowest set bit.
  // Clearing after the OR lets a same-cycle set survive only on other bits.
  always_comb begin
    grant        = '0;
    evt_d        = '0;
    short_pend_d = short_pend_q | press_w;
    long_pend_d  = long_pend_q | long_w;

    if (|long_pend_q) begin
      grant       = long_pend_q & (~long_pend_q + NUM_BTN'(1));
      long_pend_d = long_pend_d & ~grant;
      evt_d.long  = 1'b1;
    end else if (|short_pend_q) begin
      grant        = short_pend_q & (~short_pend_q + NUM_BTN'(1));
      short_pend_d = short_pend_d & ~grant;
    end

    valid_d = |grant;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grant[i]) evt_d.idx = EVT_IDX_W'(i + 1);
    end
    if (valid_d) evt_d.save = evt_d.long | (midi_in_state == MIDI_ST_LEARN);
  end

  assign btn_valid  = valid_q;
  assign btn_index  = IDX_W'(evt_q.idx);
  assign save_mode  = evt_q.save;
  assign long_press = evt_q.long;

endmodule
